// File: rtl/fd_buf.sv
// fd_buf: 2-entry fetch/decode buffer with immediate-extend select; FD_PERF_CNT_EN adds stall_cnt
module fd_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [15:0] out_imm16,
  output logic [1:0]  out_ext_op,
  input  logic        out_ready
`ifdef FD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];
  logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop;
  logic [31:0] head_instr;
  logic [5:0]  op;
  logic [1:0]  ext;
  assign in_ready   = cnt_q != 2'd2;
  assign out_valid  = cnt_q != 2'd0;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head_instr = instr_q[rd_ptr_q];
  assign op         = head_instr[31:26];
  assign ext        = op == 6'b000000 ? 2'b11 :
                      op == 6'b001111 ? 2'b10 :
                      op[5:2] == 4'b0011 ? 2'b00 : 2'b01;
  assign out_instr  = out_valid ? head_instr : 32'd0;
  assign out_pc     = out_valid ? pc_q[rd_ptr_q] : 32'd0;
  assign out_imm16  = out_valid ? head_instr[15:0] : 16'd0;
  assign out_ext_op = out_valid ? ext : 2'b11;
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = in_instr;
        pc_d[wr_ptr_q]    = in_pc;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '{default: 32'd0};
      pc_q     <= '{default: 32'd0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
  always_comb stall_cnt_d = stall_cnt_q + {31'd0, out_valid && !out_ready};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else stall_cnt_q <= stall_cnt_d;
  end
`endif
endmodule
